// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Direction encoding and prescaler width calculation.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int ps_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE into a single-cycle tick.
// Used by mod_updown_counter only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = ps_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, returning to zero on the tick.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Registered modulo-N up/down counter with load, clear, wrap pulse, sticky ovf.
// Define COUNTER_PRESCALE_EN to step only every PRESCALE enabled cycles.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             ovf,
  output logic             tc
);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("MODULUS must lie in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_ps
    $error("PRESCALE must be at least 1");
  end

  localparam logic [WIDTH:0]   MOD  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic             step;
  logic [WIDTH:0]   q_inc;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] d_sat;
  logic             wrap_up;
  logic             wrap_dn;
  logic             do_clr;
  logic             do_load;
  logic             do_step;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_ps (
    .clk  (clk),
    .reset(reset),
    .clr  (clr | load),
    .en   (en),
    .tick (step)
  );
`else
  assign step = en;
`endif

  // Next-value arithmetic in WIDTH+1 bits so MODULUS=2**WIDTH still wraps.
  always_comb begin
    q_inc   = {1'b0, q} + (WIDTH+1)'(1);
    q_dec   = q - WIDTH'(1);
    wrap_up = (q_inc == MOD);
    wrap_dn = (q == '0);
    d_sat   = ({1'b0, d} >= MOD) ? LAST : d;
    do_clr  = reset | clr;
    do_load = load & ~do_clr;
    do_step = step & ~load & ~do_clr;
  end

  assign tc = (dn == DIR_DOWN) ? (q == '0) : (q == LAST);

  // Count register, wrap pulse and sticky overflow.
  always_ff @(posedge clk) begin
    unique case (1'b1)
      do_clr: begin
        q     <= '0;
        carry <= 1'b0;
        ovf   <= 1'b0;
      end
      do_load: begin
        q     <= d_sat;
        carry <= 1'b0;
      end
      do_step: begin
        if (dn == DIR_UP) begin
          q     <= wrap_up ? '0 : q_inc[WIDTH-1:0];
          carry <= wrap_up;
          ovf   <= ovf | wrap_up;
        end else begin
          q     <= wrap_dn ? LAST : q_dec;
          carry <= wrap_dn;
          ovf   <= ovf | wrap_dn;
        end
      end
      default: begin
        carry <= 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: modulo-10 and modulo-16 counters share one stimulus stream.
// Expected values come from an integer model of the counting rules.
module tb_mod_updown_counter;

  localparam int W = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, clr, load, en, dn;
  logic [W-1:0] d;
  logic [W-1:0] qa, qb;
  logic         ca, cb, oa, ob, ta, tb;

  typedef struct {
    int q;
    bit c;
    bit o;
    bit t;
  } exp_t;

  exp_t sa[$];
  exp_t sb[$];
  exp_t xa, xb;

  int mm[2] = '{10, 16};
  int mq[2];
  int mo[2];
  int mps[2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .MODULUS(10), .PRESCALE(PS)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d),
    .en(en), .dn(dn), .q(qa), .carry(ca), .ovf(oa), .tc(ta)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(16), .PRESCALE(PS)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d),
    .en(en), .dn(dn), .q(qb), .carry(cb), .ovf(ob), .tc(tb)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's post-edge outputs.
  task automatic apply(input bit r, input bit c, input bit l,
                       input bit e, input bit dir, input int dv);
    exp_t x;
    bit   cy;
    @(negedge clk);
    reset = r;
    clr   = c;
    load  = l;
    en    = e;
    dn    = dir;
    d     = dv[W-1:0];
    for (int k = 0; k < 2; k++) begin
      cy = 1'b0;
      if (r || c) begin
        mq[k]  = 0;
        mo[k]  = 0;
        mps[k] = 0;
      end else if (l) begin
        mq[k]  = (dv >= mm[k]) ? mm[k] - 1 : dv;
        mps[k] = 0;
      end else if (e) begin
        if (mps[k] == PS - 1) begin
          mps[k] = 0;
          if (!dir) begin
            mq[k] = (mq[k] + 1) % mm[k];
            cy    = (mq[k] == 0);
          end else begin
            cy    = (mq[k] == 0);
            mq[k] = (mq[k] + mm[k] - 1) % mm[k];
          end
          if (cy) mo[k] = 1;
        end else begin
          mps[k]++;
        end
      end
      x.q = mq[k];
      x.c = cy;
      x.o = (mo[k] != 0);
      x.t = dir ? (mq[k] == 0) : (mq[k] == mm[k] - 1);
      if (k == 0) sa.push_back(x);
      else        sb.push_back(x);
    end
  endtask

  // Monitor: after every rising edge compare outputs with the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sa.size() > 0) begin
        xa = sa.pop_front();
        chk("m10_q", int'(qa), xa.q);
        chk("m10_carry", int'(ca), int'(xa.c));
        chk("m10_ovf", int'(oa), int'(xa.o));
        chk("m10_tc", int'(ta), int'(xa.t));
      end
      if (sb.size() > 0) begin
        xb = sb.pop_front();
        chk("m16_q", int'(qb), xb.q);
        chk("m16_carry", int'(cb), int'(xb.c));
        chk("m16_ovf", int'(ob), int'(xb.o));
        chk("m16_tc", int'(tb), int'(xb.t));
      end
    end
  end

  initial begin
    int r, c, l, e;
    reset = 1'b1;
    clr   = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    dn    = 1'b0;
    d     = '0;
    // Reset dominates load and enable.
    repeat (2) apply(1, 0, 1, 1, 0, 5);
    // Up count through a wrap.
    repeat (12) apply(0, 0, 0, 1, 0, 0);
    // Down count from zero wraps to the top.
    apply(1, 0, 0, 0, 1, 0);
    repeat (3) apply(0, 0, 0, 1, 1, 0);
    // Load overrides enable, then saturating load.
    apply(0, 0, 1, 1, 0, 7);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 12);
    apply(0, 0, 0, 0, 1, 0);
    // Clear beats load and drops ovf.
    apply(0, 1, 1, 1, 0, 3);
    repeat (2) apply(0, 0, 0, 0, 0, 0);
    // Enable gaps mid-window.
    repeat (4) apply(0, 0, 0, 1, 0, 0);
    repeat (2) apply(0, 0, 0, 0, 0, 0);
    repeat (5) apply(0, 0, 0, 1, 0, 0);
    // Direction flips at the wrap points.
    repeat (20) apply(0, 0, 0, 1, 1, 0);
    repeat (20) apply(0, 0, 0, 1, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      apply(r[0], c[0], l[0], e[0], $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)));
    end
    apply(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sa.size() + sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
